// File: rtl/alt_vipitc121_common_mode_switch_pkg.sv
// ---------------------------------------------------------------------------
// alt_vipitc121_common_mode_switch_pkg
// Shared definitions for the video mode switch block:
//   mode_state_e  : control states of the mode switch
//   NO_MODE_CODE  : binary code meaning "no mode selected"
//   code_in_range : true when a binary code names a real mode or no mode
// ---------------------------------------------------------------------------
package alt_vipitc121_common_mode_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } mode_state_e;

  localparam int NO_MODE_CODE = 0;

  // Codes 0..noOfModes are legal; anything above is a request for a mode
  // that does not exist in this build.
  function automatic logic code_in_range(input int code, input int noOfModes);
    return (code >= NO_MODE_CODE) && (code <= noOfModes);
  endfunction

endpackage

// File: rtl/alt_vipitc121_common_to_one_hot.sv
// ---------------------------------------------------------------------------
// alt_vipitc121_common_to_one_hot
// Combinational binary-to-one-hot mode decoder.
//   i_code   [LOG2_NO_OF_MODES-1:0] : binary mode code, 0 = no mode
//   o_oneHot [NO_OF_MODES-1:0]      : bit (code-1) set, all-zero for code 0
//                                     or for codes above NO_OF_MODES
// ---------------------------------------------------------------------------
module alt_vipitc121_common_to_one_hot #(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2
) (
  input  logic [LOG2_NO_OF_MODES-1:0] i_code,
  output logic [NO_OF_MODES-1:0]      o_oneHot
);

  // Mode index i is selected by code i+1, so code 0 leaves every bit clear
  // and at most one bit can ever match.
  always_comb begin
    o_oneHot = '0;
    for (int i = 0; i < NO_OF_MODES; i++) begin
      if (int'(i_code) == i + 1) begin
        o_oneHot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alt_vipitc121_common_mode_switch.sv
// ---------------------------------------------------------------------------
// alt_vipitc121_common_mode_switch
// Accepts a binary video mode request and applies it at the next frame
// boundary, presenting the active mode as both one-hot and binary code.
//   clk          : single clock, rising edge
//   reset_n      : asynchronous active-low reset
//   req_valid    : mode request present (held until accepted)
//   req_code     : requested binary mode code, 0 = no mode
//   req_ready    : request accepted on this edge if req_valid is high
//   frame_end    : single-cycle end-of-active-frame pulse
//   one_hot      : registered one-hot mode select, all-zero = no mode
//   cur_code     : registered binary code of the applied mode
//   pending      : accepted request waiting for the frame boundary
//   mode_changed : one-cycle pulse when one_hot/cur_code update
//   req_error    : one-cycle pulse when an out-of-range code is rejected
// ---------------------------------------------------------------------------
module alt_vipitc121_common_mode_switch
  import alt_vipitc121_common_mode_switch_pkg::*;
#(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  input  logic [LOG2_NO_OF_MODES-1:0] req_code,
  output logic                        req_ready,
  input  logic                        frame_end,
  output logic [NO_OF_MODES-1:0]      one_hot,
  output logic [LOG2_NO_OF_MODES-1:0] cur_code,
  output logic                        pending,
  output logic                        mode_changed,
  output logic                        req_error
);

  localparam logic [LOG2_NO_OF_MODES-1:0] NO_MODE = LOG2_NO_OF_MODES'(NO_MODE_CODE);

  mode_state_e                 r_state;
  mode_state_e                 w_nextState;
  logic [LOG2_NO_OF_MODES-1:0] r_latchedCode;
  logic [NO_OF_MODES-1:0]      r_oneHot;
  logic [LOG2_NO_OF_MODES-1:0] r_curCode;
  logic                        r_modeChanged;
  logic                        r_reqError;
  logic [NO_OF_MODES-1:0]      w_decoded;
  logic                        w_accept;
  logic                        w_codeValid;

  // Ready is gated by reset_n so it stays low while reset is held, even
  // though the state register already sits in IDLE.
  assign req_ready   = reset_n && (r_state == ST_IDLE);
  assign pending     = (r_state == ST_PENDING) || (r_state == ST_COMMIT);
  assign w_accept    = req_valid && req_ready;
  assign w_codeValid = code_in_range(int'(req_code), NO_OF_MODES);

  assign one_hot      = r_oneHot;
  assign cur_code     = r_curCode;
  assign mode_changed = r_modeChanged;
  assign req_error    = r_reqError;

  alt_vipitc121_common_to_one_hot #(
    .NO_OF_MODES      (NO_OF_MODES),
    .LOG2_NO_OF_MODES (LOG2_NO_OF_MODES)
  ) u_toOneHot (
    .i_code   (r_latchedCode),
    .o_oneHot (w_decoded)
  );

  // State register; reset drops any request waiting for its frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A frame_end in the accepting cycle is ignored because the FSM is still
  // in IDLE then; only frame_end seen while PENDING moves on to COMMIT.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_accept && w_codeValid) w_nextState = ST_PENDING;
      ST_PENDING: if (frame_end) w_nextState = ST_COMMIT;
      ST_COMMIT:  w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // Output registers: the new mode is loaded on the edge that leaves COMMIT,
  // so it appears together with the mode_changed pulse and req_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latchedCode <= NO_MODE;
      r_oneHot      <= '0;
      r_curCode     <= NO_MODE;
      r_modeChanged <= 1'b0;
      r_reqError    <= 1'b0;
    end else begin
      r_modeChanged <= (r_state == ST_COMMIT);
      r_reqError    <= w_accept && !w_codeValid;
      if (w_accept && w_codeValid) begin
        r_latchedCode <= req_code;
      end
      if (r_state == ST_COMMIT) begin
        r_oneHot  <= w_decoded;
        r_curCode <= r_latchedCode;
      end
    end
  end

endmodule

// File: tb/tb_alt_vipitc121_common_mode_switch.sv
// ---------------------------------------------------------------------------
// tb_alt_vipitc121_common_mode_switch
// Two instances: A with the default 3 modes, B widened to 5 modes / 3-bit
// codes so that unreachable codes (6, 7) exist. Directed scenarios first,
// then randomized requests and frame boundaries, all compared every cycle
// against a request/boundary model.
// ---------------------------------------------------------------------------
module tb_alt_vipitc121_common_mode_switch;

  logic       clk;
  logic       reset_n;
  logic       frameEnd;
  logic       reqValid [2];
  logic [7:0] reqCode  [2];

  logic       readyA, pendingA, changedA, errA;
  logic [2:0] oneHotA;
  logic [1:0] curA;
  logic       readyB, pendingB, changedB, errB;
  logic [4:0] oneHotB;
  logic [2:0] curB;

  int totalCount = 0;
  int badCount   = 0;

  // Model: mode index per instance, a waiting request, and its boundary.
  int nModes   [2] = '{3, 5};
  bit mWaiting [2];
  bit mCommit  [2];
  int mLatched [2];
  int mApplied [2];
  bit mChanged [2];
  bit mErr     [2];
  bit mAcc     [2];

  alt_vipitc121_common_mode_switch #(.NO_OF_MODES(3), .LOG2_NO_OF_MODES(2)) dutA (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (reqValid[0]),
    .req_code     (reqCode[0][1:0]),
    .req_ready    (readyA),
    .frame_end    (frameEnd),
    .one_hot      (oneHotA),
    .cur_code     (curA),
    .pending      (pendingA),
    .mode_changed (changedA),
    .req_error    (errA)
  );

  alt_vipitc121_common_mode_switch #(.NO_OF_MODES(5), .LOG2_NO_OF_MODES(3)) dutB (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (reqValid[1]),
    .req_code     (reqCode[1][2:0]),
    .req_ready    (readyB),
    .frame_end    (frameEnd),
    .one_hot      (oneHotB),
    .cur_code     (curB),
    .pending      (pendingB),
    .mode_changed (changedB),
    .req_error    (errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int expOneHot(input int code);
    return (code == 0) ? 0 : (1 << (code - 1));
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mWaiting[m] = 1'b0;
      mCommit[m]  = 1'b0;
      mLatched[m] = 0;
      mApplied[m] = 0;
      mChanged[m] = 1'b0;
      mErr[m]     = 1'b0;
      mAcc[m]     = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int m, input bit valid, input int code);
    reqValid[m] = valid;
    reqCode[m]  = 8'(code);
  endtask

  // Request a mode, give it a frame boundary, and return just after it lands.
  task automatic applyMode(input int m, input int code);
    @(negedge clk); applyStimulus(m, 1'b1, code);
    @(negedge clk); applyStimulus(m, 1'b0, 0);
    @(negedge clk); frameEnd = 1'b1;
    @(negedge clk); frameEnd = 1'b0;
    @(posedge clk); #2;
  endtask

  // Model update: a request is taken only while idle, waits for a frame
  // boundary seen after acceptance, and lands one cycle after that boundary.
  always @(posedge clk) begin
    if (reset_n) begin
      for (int m = 0; m < 2; m++) begin
        mChanged[m] = 1'b0;
        mErr[m]     = 1'b0;
        mAcc[m]     = 1'b0;
        if (mCommit[m]) begin
          mApplied[m] = mLatched[m];
          mChanged[m] = 1'b1;
          mCommit[m]  = 1'b0;
        end else if (mWaiting[m]) begin
          if (frameEnd) begin
            mWaiting[m] = 1'b0;
            mCommit[m]  = 1'b1;
          end
        end else if (reqValid[m]) begin
          mAcc[m] = 1'b1;
          if (int'(reqCode[m]) > nModes[m]) begin
            mErr[m] = 1'b1;
          end else begin
            mWaiting[m] = 1'b1;
            mLatched[m] = int'(reqCode[m]);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk); #2;
      checkOutput("A ready",   int'(readyA),   int'(reset_n && !mWaiting[0] && !mCommit[0]));
      checkOutput("A pending", int'(pendingA), int'(mWaiting[0] || mCommit[0]));
      checkOutput("A oneHot",  int'(oneHotA),  expOneHot(mApplied[0]));
      checkOutput("A curCode", int'(curA),     mApplied[0]);
      checkOutput("A changed", int'(changedA), int'(mChanged[0]));
      checkOutput("A error",   int'(errA),     int'(mErr[0]));
      checkOutput("B ready",   int'(readyB),   int'(reset_n && !mWaiting[1] && !mCommit[1]));
      checkOutput("B pending", int'(pendingB), int'(mWaiting[1] || mCommit[1]));
      checkOutput("B oneHot",  int'(oneHotB),  expOneHot(mApplied[1]));
      checkOutput("B curCode", int'(curB),     mApplied[1]);
      checkOutput("B changed", int'(changedB), int'(mChanged[1]));
      checkOutput("B error",   int'(errB),     int'(mErr[1]));
    end
  end

  initial begin
    reset_n  = 1'b0;
    frameEnd = 1'b0;
    applyStimulus(0, 1'b0, 0);
    applyStimulus(1, 1'b0, 0);
    modelReset();

    // Reset state and release
    repeat (3) @(negedge clk);
    checkOutput("rst ready",   int'(readyA),   0);
    checkOutput("rst oneHot",  int'(oneHotA),  0);
    checkOutput("rst pending", int'(pendingA), 0);
    reset_n = 1'b1;
    #1 checkOutput("post-rst ready", int'(readyA), 1);

    // Code 2, boundary five cycles later, lands the cycle after COMMIT
    applyStimulus(0, 1'b1, 2);
    @(negedge clk); applyStimulus(0, 1'b0, 0);
    checkOutput("c2 pending", int'(pendingA), 1);
    checkOutput("c2 ready",   int'(readyA),   0);
    repeat (4) @(negedge clk);
    frameEnd = 1'b1;
    @(negedge clk); frameEnd = 1'b0;
    checkOutput("c2 hold oneHot", int'(oneHotA), 0);
    checkOutput("c2 commit pending", int'(pendingA), 1);
    @(posedge clk); #2;
    checkOutput("c2 oneHot",  int'(oneHotA),  3'b010);
    checkOutput("c2 curCode", int'(curA),     2);
    checkOutput("c2 changed", int'(changedA), 1);
    checkOutput("c2 ready",   int'(readyA),   1);
    @(posedge clk); #2;
    checkOutput("c2 changed drop", int'(changedA), 0);

    // Code 3 with frame_end in the accepting cycle: that boundary is ignored
    @(negedge clk); applyStimulus(0, 1'b1, 3); frameEnd = 1'b1;
    @(negedge clk); applyStimulus(0, 1'b0, 0); frameEnd = 1'b0;
    checkOutput("c3 pending", int'(pendingA), 1);
    repeat (2) @(negedge clk);
    checkOutput("c3 no update", int'(oneHotA), 3'b010);
    checkOutput("c3 still pending", int'(pendingA), 1);
    frameEnd = 1'b1;
    @(negedge clk); frameEnd = 1'b0;
    @(posedge clk); #2;
    checkOutput("c3 oneHot", int'(oneHotA), 3'b100);
    checkOutput("c3 curCode", int'(curA), 3);

    // Mode 1 then code 0 clears the selection
    applyMode(0, 1);
    checkOutput("m1 oneHot", int'(oneHotA), 3'b001);
    applyMode(0, 0);
    checkOutput("m0 oneHot",  int'(oneHotA),  0);
    checkOutput("m0 curCode", int'(curA),     0);
    checkOutput("m0 changed", int'(changedA), 1);

    // Reset while a request is pending
    applyMode(0, 1);
    checkOutput("pre-rst oneHot", int'(oneHotA), 3'b001);
    @(negedge clk); applyStimulus(0, 1'b1, 2);
    @(negedge clk); applyStimulus(0, 1'b0, 0);
    checkOutput("pre-rst pending", int'(pendingA), 1);
    #1 reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst pending now", int'(pendingA), 0);
    checkOutput("rst oneHot now",  int'(oneHotA),  0);
    checkOutput("rst curCode now", int'(curA),     0);
    checkOutput("rst ready now",   int'(readyA),   0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    frameEnd = 1'b1;
    @(negedge clk); frameEnd = 1'b0;
    @(posedge clk); #2;
    checkOutput("post-rst frame oneHot",  int'(oneHotA),  0);
    checkOutput("post-rst frame changed", int'(changedA), 0);

    // Second request held while busy is taken the cycle after COMMIT
    @(negedge clk); applyStimulus(0, 1'b1, 2);
    @(negedge clk); applyStimulus(0, 1'b1, 3);
    @(negedge clk);
    checkOutput("hold ready", int'(readyA), 0);
    frameEnd = 1'b1;
    @(negedge clk); frameEnd = 1'b0;
    checkOutput("hold commit ready", int'(readyA), 0);
    @(posedge clk); #2;
    checkOutput("hold first oneHot", int'(oneHotA), 3'b010);
    checkOutput("hold ready back",   int'(readyA),  1);
    @(negedge clk);
    @(negedge clk); applyStimulus(0, 1'b0, 0);
    checkOutput("hold second pending", int'(pendingA), 1);
    frameEnd = 1'b1;
    @(negedge clk); frameEnd = 1'b0;
    @(posedge clk); #2;
    checkOutput("hold second oneHot", int'(oneHotA), 3'b100);

    // Widened instance: out-of-range code rejected, top mode reachable
    applyMode(1, 4);
    checkOutput("B m4 oneHot", int'(oneHotB), 5'b01000);
    @(negedge clk); applyStimulus(1, 1'b1, 7);
    @(posedge clk); #2;
    checkOutput("B c7 error",   int'(errB),     1);
    checkOutput("B c7 ready",   int'(readyB),   1);
    checkOutput("B c7 pending", int'(pendingB), 0);
    checkOutput("B c7 oneHot",  int'(oneHotB),  5'b01000);
    @(negedge clk); applyStimulus(1, 1'b0, 0);
    @(posedge clk); #2;
    checkOutput("B c7 error drop", int'(errB), 0);
    applyMode(1, 5);
    checkOutput("B m5 oneHot",  int'(oneHotB), 5'b10000);
    checkOutput("B m5 curCode", int'(curB),    5);

    // Randomized traffic; requesters hold until accepted
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 700) begin
        reset_n = 1'b0;
        modelReset();
      end
      if (i == 703) reset_n = 1'b1;
      for (int m = 0; m < 2; m++) begin
        if (!reqValid[m] || mAcc[m]) begin
          applyStimulus(m, ($urandom_range(0, 2) == 0), int'($urandom_range(0, (m == 0) ? 3 : 7)));
        end
      end
      frameEnd = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    applyStimulus(0, 1'b0, 0);
    applyStimulus(1, 1'b0, 0);
    frameEnd = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
